// File: rtl/traffic_light_fsm.sv
// Road/pedestrian phase sequencer driven by the tick strobe from the counter.
// Lamp outputs are registered from the next-state decode so they move with state.
module traffic_light_fsm #(
  parameter int unsigned GREEN_TICKS  = 4,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned WALK_TICKS   = 3,
  parameter int unsigned FLASH_TICKS  = 2
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic       enable_L,
  input  logic       enable_P,
  input  logic       ped_btn,
  output logic       light_green,
  output logic       light_yellow,
  output logic       light_red,
  output logic       ped_walk,
  output logic       ped_flash,
  output logic       ped_wait,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ROAD_GREEN  = 3'd0,
    ROAD_YELLOW = 3'd1,
    ALL_RED     = 3'd2,
    PED_WALK    = 3'd3,
    PED_FLASH   = 3'd4
  } state_t;

  localparam logic [3:0] G_LAST = 4'(GREEN_TICKS - 1);
  localparam logic [3:0] Y_LAST = 4'(YELLOW_TICKS - 1);
  localparam logic [3:0] A_LAST = 4'(ALLRED_TICKS - 1);
  localparam logic [3:0] W_LAST = 4'(WALK_TICKS - 1);
  localparam logic [3:0] F_LAST = 4'(FLASH_TICKS - 1);

  state_t     cur, nxt;
  logic [3:0] cnt, cnt_nxt, last;
  logic       req, req_nxt;
  logic       en_l_d;
  logic       tick;
  logic       at_last;
  logic       flash_nxt;

  assign tick     = enable_L & ~en_l_d;
  assign state    = cur;
  assign ped_wait = req;

  always_comb begin
    nxt  = cur;
    last = '0;
    unique case (cur)
      ROAD_GREEN:  last = G_LAST;
      ROAD_YELLOW: last = Y_LAST;
      ALL_RED:     last = A_LAST;
      PED_WALK:    last = W_LAST;
      PED_FLASH:   last = F_LAST;
      default:     last = '0;
    endcase
    at_last = tick && (cnt == last);
    case (cur)
      ROAD_GREEN:  if (at_last && req)      nxt = ROAD_YELLOW;
      ROAD_YELLOW: if (at_last)             nxt = ALL_RED;
      ALL_RED:     if (at_last && enable_P) nxt = PED_WALK;
      PED_WALK:    if (at_last)             nxt = PED_FLASH;
      PED_FLASH:   if (at_last)             nxt = ROAD_GREEN;
      default:                              nxt = ROAD_GREEN;
    endcase
  end

  // Counter saturates at the last tick so held phases exit on the next qualifying tick.
  always_comb begin
    cnt_nxt = cnt;
    if (nxt != cur)
      cnt_nxt = '0;
    else if (tick && (cnt < last))
      cnt_nxt = cnt + 4'd1;
  end

  // Entering PED_WALK clears the request even if the button is still pressed.
  always_comb begin
    req_nxt = req;
    if (ped_btn && (cur != PED_WALK))
      req_nxt = 1'b1;
    if ((nxt == PED_WALK) && (cur != PED_WALK))
      req_nxt = 1'b0;
  end

  always_comb begin
    flash_nxt = 1'b0;
    if (nxt == PED_FLASH) begin
      if (cur != PED_FLASH)
        flash_nxt = 1'b1;
      else
        flash_nxt = tick ? ~ped_flash : ped_flash;
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      cur          <= ROAD_GREEN;
      cnt          <= '0;
      req          <= 1'b0;
      en_l_d       <= 1'b0;
      light_green  <= 1'b1;
      light_yellow <= 1'b0;
      light_red    <= 1'b0;
      ped_walk     <= 1'b0;
      ped_flash    <= 1'b0;
    end else begin
      cur          <= nxt;
      cnt          <= cnt_nxt;
      req          <= req_nxt;
      en_l_d       <= enable_L;
      light_green  <= (nxt == ROAD_GREEN);
      light_yellow <= (nxt == ROAD_YELLOW);
      light_red    <= (nxt == ALL_RED) || (nxt == PED_WALK) || (nxt == PED_FLASH);
      ped_walk     <= (nxt == PED_WALK);
      ped_flash    <= flash_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: phase-duration model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_L = 1'b0;
  logic       enable_P = 1'b0;
  logic       ped_btn = 1'b0;
  logic       light_green, light_yellow, light_red;
  logic       ped_walk, ped_flash, ped_wait;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  traffic_light_fsm #(
    .GREEN_TICKS (4),
    .YELLOW_TICKS(2),
    .ALLRED_TICKS(1),
    .WALK_TICKS  (3),
    .FLASH_TICKS (2)
  ) dut (
    .clk         (clk),
    .rst_a       (rst),
    .enable_L    (enable_L),
    .enable_P    (enable_P),
    .ped_btn     (ped_btn),
    .light_green (light_green),
    .light_yellow(light_yellow),
    .light_red   (light_red),
    .ped_walk    (ped_walk),
    .ped_flash   (ped_flash),
    .ped_wait    (ped_wait),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase index walks 0..4 in order; each phase lasts dur[] ticks and
  // a phase may be extended (green without request, all-red without permit).
  int dur [5] = '{4, 2, 1, 3, 2};
  int m_ph, m_el;
  bit m_req, m_flash, m_en_d;

  always @(posedge clk or posedge rst) begin
    bit t, go, btn_ok;
    if (rst) begin
      m_ph = 0; m_el = 0; m_req = 0; m_flash = 0; m_en_d = 0;
    end else begin
      t      = enable_L && !m_en_d;
      m_en_d = enable_L;
      btn_ok = ped_btn && (m_ph != 3);
      go     = t && (m_el >= dur[m_ph] - 1);
      if (m_ph == 0) go = go && m_req;
      if (m_ph == 2) go = go && enable_P;
      if (go) begin
        m_ph    = (m_ph + 1) % 5;
        m_el    = 0;
        m_flash = (m_ph == 4);
        if (m_ph == 3) m_req = 0;
        else if (btn_ok) m_req = 1;
      end else begin
        if (t) m_el++;
        if (t && m_ph == 4) m_flash = !m_flash;
        if (btn_ok) m_req = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("state", int'(state), m_ph);
      chk("cnt", int'(dut.cnt), (m_el < dur[m_ph] - 1) ? m_el : dur[m_ph] - 1);
      chk("green", int'(light_green), int'(m_ph == 0));
      chk("yellow", int'(light_yellow), int'(m_ph == 1));
      chk("red", int'(light_red), int'(m_ph >= 2));
      chk("walk", int'(ped_walk), int'(m_ph == 3));
      chk("flash", int'(ped_flash), int'(m_flash));
      chk("wait", int'(ped_wait), int'(m_req));
      chk("onehot", int'(light_green) + int'(light_yellow) + int'(light_red), 1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable_L = 1'b0; enable_P = 1'b0; ped_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); enable_L = 1'b1;
      @(negedge clk); enable_L = 1'b0;
    end
  endtask

  task automatic press();
    @(negedge clk); ped_btn = 1'b1;
    @(negedge clk); ped_btn = 1'b0;
  endtask

  initial begin
    // reset state, checked while reset is held
    repeat (2) @(negedge clk);
    chk("rst_green", int'(light_green), 1);
    chk("rst_yellow", int'(light_yellow), 0);
    chk("rst_red", int'(light_red), 0);
    chk("rst_walk", int'(ped_walk), 0);
    chk("rst_flash", int'(ped_flash), 0);
    chk("rst_wait", int'(ped_wait), 0);
    chk("rst_state", int'(state), 0);
    rst = 1'b0;

    // no request: green holds, counter saturates
    do_tick(10);
    chk("noreq_state", int'(state), 0);
    chk("noreq_green", int'(light_green), 1);
    chk("noreq_cnt", int'(dut.cnt), 3);

    // full cycle
    do_reset();
    press();
    chk("full_wait", int'(ped_wait), 1);
    enable_P = 1'b1;
    do_tick(4);
    chk("full_yellow", int'(state), 1);
    do_tick(2);
    chk("full_allred", int'(state), 2);
    do_tick(1);
    chk("full_walk", int'(state), 3);
    chk("full_walk_lamp", int'(ped_walk), 1);
    chk("full_walk_wait", int'(ped_wait), 0);
    do_tick(3);
    chk("full_flash", int'(state), 4);
    chk("full_flash_on", int'(ped_flash), 1);
    do_tick(1);
    chk("full_flash_off", int'(ped_flash), 0);
    do_tick(1);
    chk("full_back_green", int'(state), 0);
    chk("full_back_lamp", int'(light_green), 1);

    // late request, then permit gating in ALL_RED
    do_reset();
    do_tick(6);
    press();
    do_tick(1);
    chk("late_yellow", int'(state), 1);
    enable_P = 1'b0;
    do_tick(2);
    chk("gate_allred", int'(state), 2);
    do_tick(5);
    chk("gate_hold", int'(state), 2);
    enable_P = 1'b1;
    do_tick(1);
    chk("gate_walk", int'(state), 3);

    // enable_L held high counts once
    do_reset();
    press();
    @(negedge clk); enable_L = 1'b1;
    repeat (20) @(negedge clk);
    enable_L = 1'b0;
    chk("held_cnt", int'(dut.cnt), 1);
    chk("held_state", int'(state), 0);
    do_tick(3);
    chk("held_yellow", int'(state), 1);

    // button held through walk; re-latched only by a press during flash
    enable_P = 1'b1;
    ped_btn  = 1'b1;
    do_tick(2);
    chk("hold_allred_wait", int'(ped_wait), 1);
    do_tick(1);
    chk("hold_walk", int'(state), 3);
    chk("hold_walk_wait", int'(ped_wait), 0);
    do_tick(2);
    chk("hold_walk_wait2", int'(ped_wait), 0);
    ped_btn = 1'b0;
    do_tick(1);
    chk("hold_flash", int'(state), 4);
    chk("hold_flash_wait", int'(ped_wait), 0);
    press();
    chk("flash_press_wait", int'(ped_wait), 1);
    do_tick(2);
    chk("flash_served_green", int'(state), 0);
    do_tick(4);
    chk("flash_served_yellow", int'(state), 1);

    // asynchronous reset during PED_WALK
    do_reset();
    press();
    enable_P = 1'b1;
    do_tick(7);
    chk("mid_walk", int'(state), 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_green", int'(light_green), 1);
    chk("mid_walk_off", int'(ped_walk), 0);
    chk("mid_wait", int'(ped_wait), 0);
    chk("mid_state", int'(state), 0);
    @(negedge clk);
    rst = 1'b0;
    do_tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Phase sequencer for the traffic light controller; sits directly downstream of the tick counter and consumes its `enable_L` (light timing strobe) and `enable_P` (pedestrian phase permit) outputs. It steps the road lights through green, yellow and all-red, then runs a pedestrian walk/flash phase when a pedestrian request is pending. All outputs are registered and drive the lamp/LED pins directly.

## Interface

Parameters:
- `GREEN_TICKS`, default 4: minimum ticks in ROAD_GREEN.
- `YELLOW_TICKS`, default 2: ticks in ROAD_YELLOW.
- `ALLRED_TICKS`, default 1: minimum ticks in ALL_RED.
- `WALK_TICKS`, default 3: ticks in PED_WALK.
- `FLASH_TICKS`, default 2: ticks in PED_FLASH.
- Every parameter is in the range 1..15; the phase counter is 4 bits.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst_a`, input, 1: asynchronous, active-high reset.
- `enable_L`, input, 1: light timing strobe from the counter; each rising edge is one tick.
- `enable_P`, input, 1: level; high permits entry into PED_WALK.
- `ped_btn`, input, 1: pedestrian request, sampled every clock.
- `light_green`, `light_yellow`, `light_red`, output, 1 each: road lamps, one-hot.
- `ped_walk`, output, 1: walk lamp.
- `ped_flash`, output, 1: don't-walk lamp, blinking during PED_FLASH.
- `ped_wait`, output, 1: request latched and not yet served.
- `state`, output, 3: current state code, for debug.

## Operation

- Tick detect: `en_l_d` is the registered copy of `enable_L` and resets to 0. A tick occurs in any cycle where `enable_L & ~en_l_d`. If `enable_L` is already high when reset releases, the first clock is a tick.
- States and codes: ROAD_GREEN=0, ROAD_YELLOW=1, ALL_RED=2, PED_WALK=3, PED_FLASH=4. Codes 5–7 are illegal and go to ROAD_GREEN on the next clock.
- Phase counter `cnt` (4-bit):
  - Cleared on every state change.
  - Otherwise increments on each tick and saturates at (phase ticks − 1).
- Exit condition for each state is "tick while `cnt` == N−1", where N is that state's tick parameter:
  - ROAD_GREEN → ROAD_YELLOW if the request is latched at that tick. Otherwise stay in ROAD_GREEN with `cnt` saturated; the first tick after a request arrives then exits.
  - ROAD_YELLOW → ALL_RED, unconditionally.
  - ALL_RED → PED_WALK if `enable_P`=1 at that tick. Otherwise hold in ALL_RED and re-evaluate on each later tick.
  - PED_WALK → PED_FLASH.
  - PED_FLASH → ROAD_GREEN.
- Request latch `req`:
  - Set when `ped_btn`=1.
  - Cleared on the clock that enters PED_WALK. Clear wins over a simultaneous `ped_btn`.
  - `ped_btn` is ignored while in PED_WALK.
  - A press during PED_FLASH is latched and served in the next cycle of the sequence.
- Outputs are registered and decoded from the next state, so they change on the same edge as `state`:
  - ROAD_GREEN: green.
  - ROAD_YELLOW: yellow.
  - ALL_RED: red.
  - PED_WALK: red + `ped_walk`.
  - PED_FLASH: red. `ped_flash` is set to 1 on entry, toggles on each tick, and is forced to 0 on exit.
  - `ped_wait` = `req`.

## Timing

- Reset values:
  - `state`=ROAD_GREEN, `cnt`=0, `req`=0, `en_l_d`=0.
  - `light_green`=1; `light_yellow`, `light_red`, `ped_walk`, `ped_flash`, `ped_wait` = 0.
- Latency:
  - State and outputs update on the rising edge where the tick is detected, i.e. one edge after `enable_L` rises.
  - `ped_wait` rises one edge after `ped_btn` is sampled high.
- `enable_L` held high produces exactly one tick. The next tick requires a low cycle first.
- Reset asserted mid-phase returns to reset values immediately, with no clock needed. Any latched request is lost.
- Exactly one road lamp is high at all times, including during reset.
- `ped_walk` and `light_green` are never high together.

## Test plan

- **No request:** reset, then 10 ticks with `ped_btn`=0 → remain ROAD_GREEN, `light_green`=1 throughout, `cnt` saturated at 3.
- **Full cycle:** reset; `ped_btn` pulsed for 1 cycle → `ped_wait`=1 on the next edge. Then, with `enable_P`=1:
  - 4 ticks → ROAD_YELLOW.
  - 2 ticks → ALL_RED.
  - 1 tick → PED_WALK, with `ped_wait`=0.
  - 3 ticks → PED_FLASH, `ped_flash`=1.
  - Next tick → `ped_flash`=0.
  - Next tick → ROAD_GREEN.
- **Late request:** 6 ticks without a request, then `ped_btn` → the first following tick enters ROAD_YELLOW.
- **Permit gating:** `enable_P`=0 on reaching ALL_RED → hold for 5 ticks. Raise `enable_P` → PED_WALK on the next tick.
- **Edge cases:**
  - `enable_L` held high for 20 cycles counts as one tick.
  - `ped_btn` held through PED_WALK → `ped_wait`=0 on the walk entry edge, and `ped_wait`=1 again only after a press in PED_FLASH.
- **Mid-phase reset:** assert `rst_a` asynchronously during PED_WALK → `light_green`=1, `ped_walk`=0, `ped_wait`=0 before the next clock edge.
